// File: rtl/crc8_spi_pkg.sv
// Purpose: shared types, CRC-8 constants and the 24-bit CRC step for the SPI CRC8 frame controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: state_t (IDLE/DATA/CRC/DONE), mode_t (GEN/CHECK), CRC8_POLY, CRC8_INIT, crc8_step24().
package crc8_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        GEN   = 1'b0,
        CHECK = 1'b1
    } mode_t;

    localparam logic [7:0] CRC8_POLY = 8'h1D;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    // Advance the CRC by one 24-bit word, MSB (bit 23) shifted in first.
    function automatic logic [7:0] crc8_step24(input logic [7:0] lfsr, input logic [23:0] data);
        logic [7:0] c;
        c = lfsr;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ data[i]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_spi_lfsr.sv
// Purpose: CRC-8 accumulator register; one 24-bit word folded in per enabled cycle.
// Latency: crc reflects a word one cycle after en; init takes priority over en.
// Backpressure: none; caller qualifies en with its own handshake.
//
// Ports: clk, rst (sync, active-high), init (reload 8'hFF), en (fold data), data[23:0], crc[7:0].
module crc8_spi_lfsr
    import crc8_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [23:0] data,
    output logic [7:0]  crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC8_INIT;
        end else if (en) begin
            crc_d = crc8_step24(crc_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc8_spi_frame_ctrl.sv
// Purpose: frame sequencer for the 24-bit SPI CRC8 path; GEN appends a CRC word, CHECK verifies a trailer.
// Latency: GEN data is combinational pass-through; done/crc_err/timeout pulse the cycle after the final event.
// Backpressure: GEN stalls s on m_ready; CRC word held until m_ready; idle frames abort after TO_CYC cycles.
//
// Ports: cfg_len/cfg_mode/start/abort control; s_* word input; m_* word output; busy/done/crc_err/timeout
// status pulses; crc_value holds the last completed CRC; err_cnt saturates on crc_err and timeout.
module crc8_spi_frame_ctrl
    import crc8_spi_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int TO_CYC = 1024,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [23:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [23:0]      m_data,
    output logic             m_is_crc,
    output logic             busy,
    output logic             done,
    output logic             crc_err,
    output logic             timeout,
    output logic [7:0]       crc_value,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TO_W = $clog2(TO_CYC + 1);

    state_t           state_q,     state_d;
    mode_t            mode_q,      mode_d;
    logic [LEN_W-1:0] word_cnt_q,  word_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic             done_q,      done_d;
    logic             crc_err_q,   crc_err_d;
    logic             timeout_q,   timeout_d;
    logic [7:0]       crc_value_q, crc_value_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    logic       lfsr_init;
    logic       lfsr_en;
    logic [7:0] lfsr;
    logic       s_hs;
    logic       m_hs;
    logic       word_hs;
    logic       crc_hs;
    logic       err_evt;

    crc8_spi_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .init (lfsr_init),
        .en   (lfsr_en),
        .data (s_data),
        .crc  (lfsr)
    );

    // Word-side handshakes are decoded straight from the state flop.
    always_comb begin
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_data   = 24'h0;
        m_is_crc = 1'b0;
        case (state_q)
            DATA: begin
                if (mode_q == GEN) begin
                    m_valid = s_valid;
                    s_ready = m_ready;
                    m_data  = s_data;
                end else begin
                    s_ready = 1'b1;
                end
            end
            CRC: begin
                if (mode_q == GEN) begin
                    m_valid  = 1'b1;
                    m_is_crc = 1'b1;
                    m_data   = {16'h0, lfsr};
                end else begin
                    s_ready = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign s_hs    = s_valid & s_ready;
    assign m_hs    = m_valid & m_ready;
    assign word_hs = (state_q == DATA) & s_hs;
    assign crc_hs  = (state_q == CRC) & ((mode_q == GEN) ? m_hs : s_hs);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        word_cnt_d  = word_cnt_q;
        to_cnt_d    = to_cnt_q;
        done_d      = 1'b0;
        crc_err_d   = 1'b0;
        timeout_d   = 1'b0;
        crc_value_d = crc_value_q;
        err_cnt_d   = err_cnt_q;
        lfsr_init   = 1'b0;
        lfsr_en     = 1'b0;
        err_evt     = 1'b0;

        if (abort) begin
            // abort wins over start, handshakes and timeout alike
            state_d   = IDLE;
            to_cnt_d  = '0;
            lfsr_init = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = DATA;
                        mode_d     = mode_t'(cfg_mode);
                        word_cnt_d = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                        to_cnt_d   = '0;
                        lfsr_init  = 1'b1;
                    end
                end
                DATA, CRC: begin
                    if (word_hs || crc_hs) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                        // this is the TO_CYC-th consecutive idle cycle
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        to_cnt_d  = '0;
                        lfsr_init = 1'b1;
                        err_evt   = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end

                    if (word_hs) begin
                        lfsr_en    = 1'b1;
                        word_cnt_d = word_cnt_q - LEN_W'(1);
                        if (word_cnt_q == LEN_W'(1)) begin
                            state_d = CRC;
                        end
                    end

                    if (crc_hs) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        crc_value_d = lfsr;
                        if ((mode_q == CHECK) && (s_data[7:0] != lfsr)) begin
                            crc_err_d = 1'b1;
                            err_evt   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (err_evt && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= GEN;
            word_cnt_q  <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            crc_value_q <= 8'h0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            word_cnt_q  <= word_cnt_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            timeout_q   <= timeout_d;
            crc_value_q <= crc_value_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign crc_err   = crc_err_q;
    assign timeout   = timeout_q;
    assign crc_value = crc_value_q;
    assign err_cnt   = err_cnt_q;

endmodule
